dispense_change: RTL and testbench

//  Converts a cent amount into a greedy coin breakdown (quarters, dimes, nickels, pennies).

---
 rtl/coin_pkg.sv | 23 ++
 rtl/coin_stage.sv | 43 ++++
 rtl/dispense_change.sv | 75 +++++++
 tb/tb_dispense_change.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// coin_pkg
//   Shared constants for the change dispenser: coin values in cents,
//   per-coin saturation limits, and the widths of the amount and count buses.
package coin_pkg;

  // Coin values in cents
  localparam int unsigned QUARTER = 25;
  localparam int unsigned DIME    = 10;
  localparam int unsigned NICKEL  = 5;
  localparam int unsigned PENNY   = 1;

  // Largest count each dispenser output can carry
  localparam int unsigned Q_MAX = 15;
  localparam int unsigned D_MAX = 7;
  localparam int unsigned N_MAX = 7;
  localparam int unsigned P_MAX = 7;

  // Bus widths
  localparam int unsigned CENTS_W = 9;
  localparam int unsigned Q_W     = 4;
  localparam int unsigned COIN_W  = 3;

endpackage

// File: rtl/coin_stage.sv
// coin_stage
//   Combinational greedy step for one coin denomination. It takes as many
//   coins of value COIN as fit into rem_in, capped at MAX_CNT, and passes on
//   what is left. Division by the constant coin value is done with an
//   unrolled chain of MAX_CNT compare/subtract steps, so the count saturates
//   by construction and the remainder never goes negative.
// Ports
//   rem_in   in   CENTS_W  amount still to be paid out, in cents
//   count    out  CNT_W    coins of this denomination, saturated at MAX_CNT
//   rem_out  out  CENTS_W  rem_in - COIN*count
module coin_stage
  import coin_pkg::*;
#(
  parameter int unsigned COIN    = 25,
  parameter int unsigned MAX_CNT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic [CENTS_W-1:0] rem_in,
  output logic [CNT_W-1:0]   count,
  output logic [CENTS_W-1:0] rem_out
);

  localparam logic [CENTS_W-1:0] COIN_V = CENTS_W'(COIN);

  logic [CENTS_W-1:0] rem;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    rem = rem_in;
    cnt = '0;
    // Each step removes at most one coin; after MAX_CNT steps the count is
    // capped and any excess stays in the remainder for the next stage.
    for (int i = 0; i < int'(MAX_CNT); i++) begin
      if (rem >= COIN_V) begin
        rem = rem - COIN_V;
        cnt = cnt + CNT_W'(1);
      end
    end
    rem_out = rem;
    count   = cnt;
  end

endmodule

// File: rtl/dispense_change.sv
// dispense_change
//   Converts a cent amount into a greedy coin breakdown for the coin-dispenser
//   actuators. Three coin_stage instances (25c, 10c, 5c) are chained and the
//   final remainder, saturated, becomes the penny count. All four counts are
//   registered together: one result per clock, 1-cycle latency, no enable.
//   There is no valid/ready handshake: every rising edge samples change and
//   the outputs always show the breakdown of the value sampled at the most
//   recent edge. Amounts that cannot be represented (>= 488) saturate to
//   15/7/7/7 and the residual is dropped without a flag.
// Ports
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset, clears all outputs
//   change    in   9  amount in cents, 0..511
//   quarters  out  4  25c coin count
//   dimes     out  3  10c coin count
//   nickels   out  3  5c coin count
//   pennies   out  3  1c coin count
module dispense_change
  import coin_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CENTS_W-1:0] change,
  output logic [Q_W-1:0]     quarters,
  output logic [COIN_W-1:0]  dimes,
  output logic [COIN_W-1:0]  nickels,
  output logic [COIN_W-1:0]  pennies
);

  logic [CENTS_W-1:0] r1, r2, r3;
  logic [Q_W-1:0]     q_c;
  logic [COIN_W-1:0]  d_c, n_c, p_c;

  coin_stage #(.COIN(QUARTER), .MAX_CNT(Q_MAX), .CNT_W(Q_W)) u_quarter (
    .rem_in (change),
    .count  (q_c),
    .rem_out(r1)
  );

  coin_stage #(.COIN(DIME), .MAX_CNT(D_MAX), .CNT_W(COIN_W)) u_dime (
    .rem_in (r1),
    .count  (d_c),
    .rem_out(r2)
  );

  coin_stage #(.COIN(NICKEL), .MAX_CNT(N_MAX), .CNT_W(COIN_W)) u_nickel (
    .rem_in (r2),
    .count  (n_c),
    .rem_out(r3)
  );

  // Whatever is left after nickels is paid in pennies, capped at P_MAX;
  // above that the residual is dropped.
  always_comb begin
    p_c = r3[COIN_W-1:0];
    if (r3 > CENTS_W'(P_MAX)) begin
      p_c = COIN_W'(P_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quarters <= '0;
      dimes    <= '0;
      nickels  <= '0;
      pennies  <= '0;
    end else begin
      quarters <= q_c;
      dimes    <= d_c;
      nickels  <= n_c;
      pennies  <= p_c;
    end
  end

endmodule

// File: tb/tb_dispense_change.sv
// tb_dispense_change
//   Self-checking bench for dispense_change: directed vector table, latency
//   and reset sequences, an exhaustive sweep and random stimulus checked
//   against an arithmetic reference model through an expected-value queue.
module tb_dispense_change;

  logic       clk;
  logic       rst_n;
  logic [8:0] change;
  logic [3:0] quarters;
  logic [2:0] dimes;
  logic [2:0] nickels;
  logic [2:0] pennies;

  int checks;
  int errors;

  // Packed {q[3:0], d[2:0], n[2:0], p[2:0]}
  logic [12:0] exp_q[$];

  typedef struct {
    logic [8:0] chg;
    logic [3:0] q;
    logic [2:0] d;
    logic [2:0] n;
    logic [2:0] p;
  } vec_t;

  vec_t vecs[8];

  dispense_change dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .change  (change),
    .quarters(quarters),
    .dimes   (dimes),
    .nickels (nickels),
    .pennies (pennies)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [12:0] model(int c);
    int q, d, n, p, r;
    q = min_i(c / 25, 15);
    r = c - 25 * q;
    d = min_i(r / 10, 7);
    r = r - 10 * d;
    n = min_i(r / 5, 7);
    r = r - 5 * n;
    p = min_i(r, 7);
    return {q[3:0], d[2:0], n[2:0], p[2:0]};
  endfunction

  function automatic logic [12:0] outs();
    return {quarters, dimes, nickels, pennies};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got q=%0d d=%0d n=%0d p=%0d, expected q=%0d d=%0d n=%0d p=%0d",
               name, got[12:9], got[8:6], got[5:3], got[2:0],
               exp[12:9], exp[8:6], exp[5:3], exp[2:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, return 1 time unit after the next rising edge.
  task automatic apply(input logic [8:0] v);
    @(negedge clk);
    change = v;
    @(posedge clk);
    #1;
  endtask

  // Push the model value, clock the DUT, then compare against the queue head.
  task automatic sb_apply(input logic [8:0] v, input string name);
    logic [12:0] e;
    exp_q.push_back(model(int'(v)));
    apply(v);
    e = exp_q.pop_front();
    check(name, outs(), e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    change = 9'd37;

    vecs[0] = '{9'd0,   4'd0,  3'd0, 3'd0, 3'd0};
    vecs[1] = '{9'd99,  4'd3,  3'd2, 3'd0, 3'd4};
    vecs[2] = '{9'd30,  4'd1,  3'd0, 3'd1, 3'd0};
    vecs[3] = '{9'd399, 4'd15, 3'd2, 3'd0, 3'd4};
    vecs[4] = '{9'd400, 4'd15, 3'd2, 3'd1, 3'd0};
    vecs[5] = '{9'd487, 4'd15, 3'd7, 3'd7, 3'd7};
    vecs[6] = '{9'd511, 4'd15, 3'd7, 3'd7, 3'd7};
    vecs[7] = '{9'd37,  4'd1,  3'd1, 3'd0, 3'd2};

    // --- reset held with change=37: outputs stay zero across edges
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", outs(), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset_37", outs(), {4'd1, 3'd1, 3'd0, 3'd2});

    // --- directed table
    foreach (vecs[i]) begin
      apply(vecs[i].chg);
      check($sformatf("table_%0d", vecs[i].chg), outs(),
            {vecs[i].q, vecs[i].d, vecs[i].n, vecs[i].p});
    end

    // --- latency: 37 -> 99 -> 5 on consecutive edges
    @(negedge clk);
    change = 9'd37;
    @(posedge clk);
    #1;
    check("lat_37", outs(), {4'd1, 3'd1, 3'd0, 3'd2});
    change = 9'd99;  // before the next edge, output must still reflect 37
    #2;
    check("lat_hold_37", outs(), {4'd1, 3'd1, 3'd0, 3'd2});
    @(posedge clk);
    #1;
    check("lat_99", outs(), {4'd3, 3'd2, 3'd0, 3'd4});
    change = 9'd5;
    @(posedge clk);
    #1;
    check("lat_5", outs(), {4'd0, 3'd0, 3'd1, 3'd0});

    // --- held input: outputs stay constant
    repeat (3) @(posedge clk);
    #1;
    check("held_5", outs(), {4'd0, 3'd0, 3'd1, 3'd0});

    // --- exhaustive sweep with a mid-sweep async reset pulse
    for (int v = 0; v < 512; v++) begin
      sb_apply(9'(v), "sweep");
      if (v <= 487) begin
        checks++;
        if (int'(quarters) * 25 + int'(dimes) * 10 + int'(nickels) * 5 + int'(pennies) != v) begin
          errors++;
          $display("FAIL sum_%0d: got sum=%0d, expected %0d", v,
                   int'(quarters) * 25 + int'(dimes) * 10 + int'(nickels) * 5 + int'(pennies), v);
        end
      end
      if (v == 250) begin
        #2;
        rst_n = 1'b0;   // no clock edge in this window: clear must be asynchronous
        #1;
        check("async_clear_mid_sweep", outs(), 13'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_apply(9'd250, "re_present_250");
      end
    end

    // --- random stimulus
    for (int k = 0; k < 300; k++) begin
      sb_apply(9'($urandom_range(0, 511)), "random");
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
